// File: rtl/register_file_mp.sv
// Multi-read-port register file with a per-register pending-write scoreboard.
// Define RF_BYPASS_EN to forward a same-cycle write to matching read ports.
module register_file_mp #(
    parameter int unsigned ADDRSIZE = 5,
    parameter int unsigned WORDSIZE = 32,
    parameter int unsigned NREAD    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         regWrite,
    input  logic [ADDRSIZE-1:0]          writeReg,
    input  logic [WORDSIZE-1:0]          writeData,
    input  logic [NREAD*ADDRSIZE-1:0]    readReg,
    output logic [NREAD*WORDSIZE-1:0]    readData,
    input  logic                         issueValid,
    input  logic [ADDRSIZE-1:0]          issueReg,
    output logic [NREAD-1:0]             busy
);

    localparam int unsigned RFSIZE = 1 << ADDRSIZE;

    logic [WORDSIZE-1:0] regs    [RFSIZE];
    logic [ADDRSIZE-1:0] raddrQ  [NREAD];
    logic [RFSIZE-1:0]   pending;
    logic                writeHit;
    logic                issueHit;

    // Register 0 is hardwired: it never accepts a write or a pending mark.
    assign writeHit = regWrite && (writeReg != '0);
    assign issueHit = issueValid && (issueReg != '0);

    // Array, scoreboard and sampled read addresses; set beats clear on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs    <= '{default: '0};
            raddrQ  <= '{default: '0};
            pending <= '0;
        end else begin
            if (writeHit) begin
                regs[writeReg]    <= writeData;
                pending[writeReg] <= 1'b0;
            end
            if (issueHit) begin
                pending[issueReg] <= 1'b1;
            end
            for (int unsigned k = 0; k < NREAD; k++) begin
                raddrQ[k] <= readReg[k*ADDRSIZE +: ADDRSIZE];
            end
        end
    end

    // Read ports look up the array at the address sampled on the last edge.
    always_comb begin
        readData = '0;
        busy     = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            if (raddrQ[k] != '0) begin
                readData[k*WORDSIZE +: WORDSIZE] = regs[raddrQ[k]];
                busy[k]                          = pending[raddrQ[k]];
`ifdef RF_BYPASS_EN
                if (writeHit && (writeReg == raddrQ[k])) begin
                    readData[k*WORDSIZE +: WORDSIZE] = writeData;
                    busy[k] = issueHit && (issueReg == writeReg);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed self-checking bench for register_file_mp (four read ports).
// Expectations follow the RF_BYPASS_EN setting of the build.
module tb_register_file_mp;

    localparam int unsigned A  = 5;
    localparam int unsigned W  = 32;
    localparam int unsigned NR = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              regWrite;
    logic [A-1:0]      writeReg;
    logic [W-1:0]      writeData;
    logic [NR*A-1:0]   readReg;
    logic [NR*W-1:0]   readData;
    logic              issueValid;
    logic [A-1:0]      issueReg;
    logic [NR-1:0]     busy;

    int total = 0;
    int bad   = 0;

    register_file_mp #(.ADDRSIZE(A), .WORDSIZE(W), .NREAD(NR)) dut (
        .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
        .writeData(writeData), .readReg(readReg), .readData(readData),
        .issueValid(issueValid), .issueReg(issueReg), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regWrite   = 1'b0;
        writeReg   = '0;
        writeData  = '0;
        issueValid = 1'b0;
        issueReg   = '0;
    endtask

    function automatic logic [W-1:0] portData(input int k);
        return readData[k*W +: W];
    endfunction

    task automatic test_reset();
        idle();
        readReg = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 0; r < 32; r++) begin
            readReg = {A'(r), A'(r), A'(r), A'(r)};
            tick();
            total++;
            if (portData(0) !== 32'h0 || portData(1) !== 32'h0 || busy !== 4'b0000) begin
                bad++;
                $display("FAIL reset_read x%0d: p0=%h p1=%h busy=%b want 0/0/0000",
                         r, portData(0), portData(1), busy);
            end
        end
    endtask

    task automatic test_write_read();
        regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEADBEEF;
        tick();
        idle();
        readReg = {5'd0, 5'd0, 5'd0, 5'd5};
        tick();
        total++;
        if (portData(0) !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_x5: got=%h want=deadbeef", portData(0));
        end
        regWrite = 1'b1; writeReg = 5'd0; writeData = 32'h1234;
        readReg = '0;
        tick();
        idle();
        tick();
        total++;
        if (portData(0) !== 32'h0 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL write_x0: got=%h busy=%b want=0 busy=0", portData(0), busy[0]);
        end
    endtask

    task automatic test_scoreboard();
        issueValid = 1'b1; issueReg = 5'd7;
        tick();
        idle();
        readReg = {5'd0, 5'd0, 5'd0, 5'd7};
        tick();
        total++;
        if (busy[0] !== 1'b1 || portData(0) !== 32'h0) begin
            bad++;
            $display("FAIL issue_x7: busy=%b data=%h want busy=1 data=0", busy[0], portData(0));
        end
        regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h55;
        tick();
        idle();
        total++;
        if (busy[0] !== 1'b0 || portData(0) !== 32'h55) begin
            bad++;
            $display("FAIL clear_x7: busy=%b data=%h want busy=0 data=55", busy[0], portData(0));
        end
        regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h66;
        issueValid = 1'b1; issueReg = 5'd7;
        tick();
        idle();
        total++;
        if (busy[0] !== 1'b1 || portData(0) !== 32'h66) begin
            bad++;
            $display("FAIL set_wins_x7: busy=%b data=%h want busy=1 data=66", busy[0], portData(0));
        end
    endtask

    task automatic test_bypass();
        logic [W-1:0] expSame;
        logic         expBusy;
        readReg = {5'd0, 5'd0, 5'd5, 5'd3};
        tick();
        total++;
        if (portData(0) !== 32'h0) begin
            bad++;
            $display("FAIL bypass_pre_x3: got=%h want=0", portData(0));
        end
        regWrite = 1'b1; writeReg = 5'd3; writeData = 32'hA5A5A5A5;
        #1;
`ifdef RF_BYPASS_EN
        expSame = 32'hA5A5A5A5;
`else
        expSame = 32'h0;
`endif
        total++;
        if (portData(0) !== expSame || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL bypass_same_cycle: got=%h busy=%b want=%h busy=0",
                     portData(0), busy[0], expSame);
        end
        total++;
        if (portData(1) !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL bypass_other_port: got=%h want=deadbeef", portData(1));
        end
        tick();
        idle();
        total++;
        if (portData(0) !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL bypass_next_cycle: got=%h want=a5a5a5a5", portData(0));
        end
        regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h3;
        issueValid = 1'b1; issueReg = 5'd3;
        #1;
`ifdef RF_BYPASS_EN
        expBusy = 1'b1;
`else
        expBusy = 1'b0;
`endif
        total++;
        if (busy[0] !== expBusy) begin
            bad++;
            $display("FAIL bypass_busy_issue: got=%b want=%b", busy[0], expBusy);
        end
        tick();
        idle();
        total++;
        if (busy[0] !== 1'b1 || portData(0) !== 32'h3) begin
            bad++;
            $display("FAIL bypass_busy_after: busy=%b data=%h want busy=1 data=3", busy[0], portData(0));
        end
    endtask

    task automatic test_reset_midop();
        regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h77;
        tick();
        idle();
        issueValid = 1'b1; issueReg = 5'd9;
        readReg = {5'd0, 5'd0, 5'd5, 5'd9};
        tick();
        idle();
        total++;
        if (portData(0) !== 32'h77 || busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_x9: data=%h busy=%b want 77/1", portData(0), busy[0]);
        end
        reset = 1'b1;
        regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h88;
        issueValid = 1'b1; issueReg = 5'd9;
        tick();
        reset = 1'b0;
        idle();
        total++;
        if (readData !== '0 || busy !== 4'b0000) begin
            bad++;
            $display("FAIL after_reset: data=%h busy=%b want all 0", readData, busy);
        end
        tick();
        total++;
        if (portData(0) !== 32'h0 || busy[0] !== 1'b0 || portData(1) !== 32'h0) begin
            bad++;
            $display("FAIL reset_x9: x9=%h busy=%b x5=%h want 0/0/0",
                     portData(0), busy[0], portData(1));
        end
    endtask

    task automatic test_multiport();
        regWrite = 1'b1; writeReg = 5'd2; writeData = 32'h10;
        tick();
        idle();
        readReg = {5'd2, 5'd2, 5'd2, 5'd2};
        tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (portData(k) !== 32'h10 || busy[k] !== 1'b0) begin
                bad++;
                $display("FAIL multi_same_p%0d: data=%h busy=%b want 10/0", k, portData(k), busy[k]);
            end
        end
        regWrite = 1'b1; writeReg = 5'd4; writeData = 32'h44;
        tick();
        writeReg = 5'd6; writeData = 32'h66;
        tick();
        idle();
        issueValid = 1'b1; issueReg = 5'd6;
        readReg = {5'd6, 5'd0, 5'd4, 5'd2};
        tick();
        idle();
        total++;
        if (readData !== {32'h66, 32'h0, 32'h44, 32'h10} || busy !== 4'b1000) begin
            bad++;
            $display("FAIL multi_mixed: data=%h busy=%b want 00000066_00000000_00000044_00000010 busy=1000",
                     readData, busy);
        end
    endtask

    initial begin
        reset = 1'b0;
        readReg = '0;
        idle();
        test_reset();
        test_write_read();
        test_scoreboard();
        test_bypass();
        test_reset_midop();
        test_multiport();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
